hilo_muldiv_seq: RTL and testbench

Multi-cycle sequencer owning the HI/LO register pair for the MIPS datapath. It executes MULT, MULTU, MADD, MSUB, MTHI and MTLO issued from the EX stage using an iterative 1-bit-per-cycle shift-add multiplier. While an operation is in flight it raises `Busy` and generates `Stall` for any dependent HI/LO access. It replaces the single-cycle HI/LO write path driven by the decoder's `Hi_write`/`Lo_write`.

---
 rtl/hilo_pkg.sv | 19 +
 rtl/hilo_muldiv_seq_mul_core.sv | 75 +++++++
 rtl/hilo_muldiv_seq.sv | 127 ++++++++++++
 tb/tb_hilo_muldiv_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared constants for the HI/LO multiply sequencer: op encodings, FSM states and default width.
package hilo_pkg;

  localparam int unsigned HILO_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MADD  = 3'd2;
  localparam logic [2:0] OP_MSUB  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/hilo_muldiv_seq_mul_core.sv
// Iterative 1-bit-per-cycle shift-add multiplier on magnitudes, with the sign
// re-applied to the 2W product once the last step has been taken.
module hilo_mul_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 last,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [2*WIDTH-1:0] raw;

  // Operand magnitude, one add per step, and the load/step register update
  always_comb begin
    abs_a    = (signed_mode && a[WIDTH-1]) ? (-a) : a;
    abs_b    = (signed_mode && b[WIDTH-1]) ? (-b) : b;
    sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    if (load) begin
      mcand_d  = abs_a;
      mplier_d = abs_b;
      acc_d    = '0;
      cnt_d    = CW'(WIDTH - 1);
      neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      // the multiplier register doubles as the low half of the product
      acc_d    = sum[WIDTH:1];
      mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
      cnt_d    = cnt_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d    = cnt_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  assign last    = (cnt_q == '0);
  assign raw     = {acc_q, mplier_q};
  assign product = neg_q ? (-raw) : raw;

endmodule

// File: rtl/hilo_muldiv_seq.sv
// HI/LO register owner: sequences MULT/MULTU/MADD/MSUB through the shift-add
// core, performs MTHI/MTLO directly, and stalls dependent HI/LO accesses.
module hilo_muldiv_seq
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = HILO_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] RsVal,
  input  logic [WIDTH-1:0] RtVal,
  input  logic             HiLoRd,
  input  logic             Abort,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             Stall
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             load, step, last, signed_mode;
  logic [2*WIDTH-1:0] product, hilo_res;

  hilo_mul_core #(.WIDTH(WIDTH)) u_core (
    .clk         (Clk),
    .rst         (Rst),
    .load        (load),
    .step        (step),
    .signed_mode (signed_mode),
    .a           (RsVal),
    .b           (RtVal),
    .last        (last),
    .product     (product)
  );

  // Sequencer next state, HI/LO writes and accumulate/subtract
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    signed_mode = (Op != OP_MULTU);
    hilo_res    = {hi_q, lo_q};
    case (state_q)
      ST_IDLE: begin
        if (Start && !Abort) begin
          case (Op)
            OP_MTHI: hi_d = RsVal;
            OP_MTLO: lo_d = RsVal;
            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
              load    = 1'b1;
              op_d    = Op;
              state_d = ST_MUL;
            end
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          if (last) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_MUL;
          end
        end
      end
      ST_WB: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else begin
          case (op_q)
            OP_MADD: hilo_res = {hi_q, lo_q} + product;
            OP_MSUB: hilo_res = {hi_q, lo_q} - product;
            default: hilo_res = product;
          endcase
          {hi_d, lo_d} = hilo_res;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Architectural and control registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      op_q    <= 3'd0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign Hi    = hi_q;
  assign Lo    = lo_q;
  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Stall = busy_q & (Start | HiLoRd);

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Randomized and directed bench for hilo_muldiv_seq against an arithmetic HI/LO model.
module tb_hilo_muldiv_seq;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        Rst, Start, HiLoRd, Abort, Busy, Done, Stall;
  logic [2:0]  Op;
  logic [31:0] RsVal, RtVal, Hi, Lo;
  logic [31:0] hi_m, lo_m;
  int          checks = 0;
  int          errors = 0;

  hilo_muldiv_seq #(.WIDTH(32)) dut (
    .Clk(clk), .Rst(Rst), .Start(Start), .Op(Op), .RsVal(RsVal), .RtVal(RtVal),
    .HiLoRd(HiLoRd), .Abort(Abort), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done),
    .Stall(Stall)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: full-width product from plain arithmetic, then accumulate mod 2^64
  task automatic model_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p, cur;
    if (op == OP_MULTU) p = {32'h0, a} * {32'h0, b};
    else                p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    cur = {hi_m, lo_m};
    if (op == OP_MADD)      cur = cur + p;
    else if (op == OP_MSUB) cur = cur - p;
    else                    cur = p;
    {hi_m, lo_m} = cur;
  endtask

  task automatic write_reg(input logic [2:0] op, input logic [31:0] v);
    Start = 1'b1; Op = op; RsVal = v; RtVal = $urandom;
    tick();
    Start = 1'b0;
    if (op == OP_MTHI)      hi_m = v;
    else if (op == OP_MTLO) lo_m = v;
    check_eq("wr_busy", Busy, 0);
    check_eq("wr_done", Done, 0);
    check_eq("wr_hi", Hi, hi_m);
    check_eq("wr_lo", Lo, lo_m);
  endtask

  // mode 0: plain, 1: stall/ignored-start/re-present, 2: abort at N+5
  task automatic do_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int mode);
    logic [31:0] hs, ls, mtlo_v;
    bit bad, saw_done;
    hs = hi_m; ls = lo_m; bad = 0; saw_done = 0;
    mtlo_v = $urandom;
    Start = 1'b1; Op = op; RsVal = a; RtVal = b;
    tick();
    Start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (!Busy || Done) bad = 1;
      if (mode == 2 && c == 5) begin
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        break;
      end
      if (mode == 1 && c == 5) begin
        HiLoRd = 1'b1; #1;
        check_eq("stall_rd", Stall, 1);
        HiLoRd = 1'b0;
      end
      if (mode == 1 && c == 6) begin
        Start = 1'b1; Op = OP_MTLO; RsVal = 32'hDEADBEEF; #1;
        check_eq("stall_start", Stall, 1);
      end
      if (mode == 1 && c == 7) Start = 1'b0;
      tick();
    end
    check_eq("busy_window", bad, 0);
    if (mode == 2) begin
      check_eq("abort_busy", Busy, 0);
      for (int k = 0; k < 35; k++) begin
        if (Done) saw_done = 1;
        tick();
      end
      check_eq("abort_nodone", saw_done, 0);
      check_eq("abort_hi", Hi, hs);
      check_eq("abort_lo", Lo, ls);
    end else begin
      model_mul(op, a, b);
      check_eq("done_pulse", Done, 1);
      check_eq("done_busy", Busy, 0);
      check_eq("mul_hi", Hi, hi_m);
      check_eq("mul_lo", Lo, lo_m);
      if (mode == 1) begin
        Start = 1'b1; Op = OP_MTLO; RsVal = mtlo_v; #1;
        check_eq("represent_stall", Stall, 0);
      end
      tick();
      Start = 1'b0;
      check_eq("done_once", Done, 0);
      if (mode == 1) begin
        lo_m = mtlo_v;
        check_eq("represent_lo", Lo, lo_m);
      end
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 32'h0;
      1: pick = 32'hFFFFFFFF;
      2: pick = 32'h80000000;
      3: pick = 32'h1;
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] rop;
    Rst = 1'b1; Start = 1'b0; Op = 3'd0; RsVal = 32'h0; RtVal = 32'h0;
    HiLoRd = 1'b1; Abort = 1'b0;
    hi_m = 32'h0; lo_m = 32'h0;
    #2;
    check_eq("rst_hi", Hi, 0);
    check_eq("rst_lo", Lo, 0);
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_done", Done, 0);
    check_eq("rst_stall", Stall, 0);
    HiLoRd = 1'b0;
    repeat (2) @(posedge clk);
    #1 Rst = 1'b0;
    tick();

    do_mul(OP_MULT, 32'h80000000, 32'h80000000, 0);
    check_eq("min_sq_hi", Hi, 32'h40000000);
    check_eq("min_sq_lo", Lo, 32'h0);
    do_mul(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check_eq("umax_hi", Hi, 32'hFFFFFFFE);
    check_eq("umax_lo", Lo, 32'h00000001);
    do_mul(OP_MULT, 32'hFFFFFFFD, 32'd7, 0);
    check_eq("neg21_lo", Lo, 32'hFFFFFFEB);
    do_mul(OP_MADD, 32'd5, 32'd5, 0);
    check_eq("madd_hi", Hi, 32'h0);
    check_eq("madd_lo", Lo, 32'h4);
    do_mul(OP_MSUB, 32'd2, 32'd3, 1);
    check_eq("msub_hi", Hi, 32'hFFFFFFFF);

    write_reg(OP_MTHI, 32'hAAAAAAAA);
    write_reg(OP_MTLO, 32'hAAAAAAAA);
    do_mul(OP_MULT, 32'h12345678, 32'h9ABCDEF0, 2);

    // Abort and Start together in IDLE: nothing happens
    Start = 1'b1; Abort = 1'b1; Op = OP_MTHI; RsVal = 32'h55555555;
    tick();
    Op = OP_MULT;
    tick();
    Start = 1'b0; Abort = 1'b0;
    check_eq("abst_hi", Hi, hi_m);
    check_eq("abst_busy", Busy, 0);

    // Reset in the middle of a multiply
    Start = 1'b1; Op = OP_MULTU; RsVal = 32'hFFFF0000; RtVal = 32'h0000FFFF;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    HiLoRd = 1'b1;
    Rst = 1'b1; #1;
    check_eq("mrst_hi", Hi, 0);
    check_eq("mrst_lo", Lo, 0);
    check_eq("mrst_busy", Busy, 0);
    check_eq("mrst_done", Done, 0);
    check_eq("mrst_stall", Stall, 0);
    HiLoRd = 1'b0;
    hi_m = 32'h0; lo_m = 32'h0;
    tick();
    Rst = 1'b0;
    tick();
    write_reg(OP_MTHI, 32'h1234);
    check_eq("mthi_1234", Hi, 32'h00001234);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      if (rop <= OP_MSUB) do_mul(rop, pick(), pick(), 0);
      else                write_reg(rop, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
